// File: rtl/signal_conflict_monitor.sv
// Safety monitor for the traffic controller's light codes. It validates each sample,
// decodes legal codes onto one-hot lamps, and latches a fault with flashing red until acknowledged.
module signal_conflict_monitor #(
  parameter int MIN_YELLOW = 3,
  parameter int MIN_CLEAR  = 2,
  parameter int FLASH_HALF = 4
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [1:0] hwy,
  input  logic [1:0] cntry,
  input  logic       ack,
  output logic [2:0] hwy_lamp,
  output logic [2:0] cntry_lamp,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam int YW = (MIN_YELLOW > 0) ? $clog2(MIN_YELLOW + 1) : 1;
  localparam int CW = (MIN_CLEAR > 0) ? $clog2(MIN_CLEAR + 1) : 1;
  localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

  localparam logic [YW-1:0] YSAT  = YW'(MIN_YELLOW);
  localparam logic [CW-1:0] CSAT  = CW'(MIN_CLEAR);
  localparam logic [FW-1:0] FLAST = FW'(FLASH_HALF - 1);

  localparam logic [1:0] ST_ARM   = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  localparam logic [1:0] C_RED    = 2'd0;
  localparam logic [1:0] C_YELLOW = 2'd1;
  localparam logic [1:0] C_GREEN  = 2'd2;
  localparam logic [1:0] C_BAD    = 2'd3;

  localparam logic [2:0] FC_NONE      = 3'd0;
  localparam logic [2:0] FC_INVALID   = 3'd1;
  localparam logic [2:0] FC_CONFLICT  = 3'd2;
  localparam logic [2:0] FC_SEQUENCE  = 3'd3;
  localparam logic [2:0] FC_SHORT_Y   = 3'd4;
  localparam logic [2:0] FC_SHORT_CLR = 3'd5;

  localparam logic [2:0] LAMP_RED = 3'b100;

  logic [1:0]    state_q, state_d;
  logic          fault_q, fault_d;
  logic [2:0]    code_q, code_d;
  logic [2:0]    hwy_lamp_q, hwy_lamp_d;
  logic [2:0]    cntry_lamp_q, cntry_lamp_d;
  logic          flash_q, flash_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [CW-1:0] clr_q, clr_d;

  logic [1:0][1:0] cur;
  logic [1:0][2:0] dec;
  logic [1:0]      bad, nonred, seq_err, short_y, short_c;
  logic            both_red, run, advance;
  logic [2:0]      viol;

  assign cur      = {cntry, hwy};
  assign both_red = ~|nonred;
  assign run      = (state_q == ST_RUN);
  assign advance  = (state_q != ST_FAULT) && (viol == FC_NONE);

  // Per-approach decode, checks and yellow-run counter; index 0 is highway, 1 is country road.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_appr
      logic [1:0]    prev_q;
      logic [YW-1:0] ycnt_q, ycnt_d;

      assign dec[gi] = (cur[gi] == C_YELLOW) ? 3'b010 :
                       (cur[gi] == C_GREEN)  ? 3'b001 : LAMP_RED;

      assign bad[gi]    = (cur[gi] == C_BAD);
      assign nonred[gi] = (cur[gi] != C_RED);

      assign seq_err[gi] = ((prev_q == C_GREEN)  && (cur[gi] == C_RED))    ||
                           ((prev_q == C_YELLOW) && (cur[gi] == C_GREEN))  ||
                           ((prev_q == C_RED)    && (cur[gi] == C_YELLOW));

      assign short_y[gi] = (prev_q == C_YELLOW) && (cur[gi] == C_RED) && (ycnt_q < YSAT);
      assign short_c[gi] = (prev_q == C_RED) && (cur[gi] == C_GREEN) && (clr_q < CSAT);

      assign ycnt_d = (cur[gi] != C_YELLOW) ? '0 :
                      (ycnt_q == YSAT)      ? YSAT : ycnt_q + 1'b1;

      // History only advances on accepted samples; any fault wipes the yellow run.
      always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
          prev_q <= C_RED;
          ycnt_q <= '0;
        end else if (advance) begin
          prev_q <= cur[gi];
          ycnt_q <= ycnt_d;
        end else begin
          ycnt_q <= '0;
        end
      end
    end
  endgenerate

  assign clr_d = !both_red      ? '0 :
                 (clr_q == CSAT) ? CSAT : clr_q + 1'b1;

  // Lowest fault code wins; history-based checks need a valid previous sample, i.e. RUN.
  always_comb begin
    viol = FC_NONE;
    if (|bad)                viol = FC_INVALID;
    else if (&nonred)        viol = FC_CONFLICT;
    else if (run && |seq_err) viol = FC_SEQUENCE;
    else if (run && |short_y) viol = FC_SHORT_Y;
    else if (run && |short_c) viol = FC_SHORT_CLR;
  end

  always_comb begin
    state_d      = state_q;
    fault_d      = fault_q;
    code_d       = code_q;
    flash_d      = flash_q;
    fcnt_d       = fcnt_q;
    hwy_lamp_d   = dec[0];
    cntry_lamp_d = dec[1];
    case (state_q)
      ST_ARM, ST_RUN: begin
        if (viol != FC_NONE) begin
          state_d      = ST_FAULT;
          fault_d      = 1'b1;
          code_d       = viol;
          flash_d      = 1'b1;
          fcnt_d       = '0;
          hwy_lamp_d   = LAMP_RED;
          cntry_lamp_d = LAMP_RED;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FAULT: begin
        if (ack && both_red) begin
          state_d      = ST_ARM;
          fault_d      = 1'b0;
          code_d       = FC_NONE;
          flash_d      = 1'b0;
          fcnt_d       = '0;
          hwy_lamp_d   = LAMP_RED;
          cntry_lamp_d = LAMP_RED;
        end else begin
          if (fcnt_q == FLAST) begin
            fcnt_d  = '0;
            flash_d = ~flash_q;
          end else begin
            fcnt_d = fcnt_q + 1'b1;
          end
          hwy_lamp_d   = {flash_d, 2'b00};
          cntry_lamp_d = {flash_d, 2'b00};
        end
      end
      default: begin
        state_d      = ST_ARM;
        fault_d      = 1'b0;
        code_d       = FC_NONE;
        flash_d      = 1'b0;
        fcnt_d       = '0;
        hwy_lamp_d   = LAMP_RED;
        cntry_lamp_d = LAMP_RED;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q      <= ST_ARM;
      fault_q      <= 1'b0;
      code_q       <= FC_NONE;
      flash_q      <= 1'b0;
      fcnt_q       <= '0;
      clr_q        <= '0;
      hwy_lamp_q   <= LAMP_RED;
      cntry_lamp_q <= LAMP_RED;
    end else begin
      state_q      <= state_d;
      fault_q      <= fault_d;
      code_q       <= code_d;
      flash_q      <= flash_d;
      fcnt_q       <= fcnt_d;
      clr_q        <= advance ? clr_d : '0;
      hwy_lamp_q   <= hwy_lamp_d;
      cntry_lamp_q <= cntry_lamp_d;
    end
  end

  assign hwy_lamp   = hwy_lamp_q;
  assign cntry_lamp = cntry_lamp_q;
  assign fault      = fault_q;
  assign fault_code = code_q;

endmodule

// File: tb/tb_signal_conflict_monitor.sv
// Bench for signal_conflict_monitor: directed scenarios with literal expectations plus
// randomized traffic phases, all compared every cycle against a behavioural model.
module tb_signal_conflict_monitor;
  localparam int MIN_YELLOW = 3;
  localparam int MIN_CLEAR  = 2;
  localparam int FLASH_HALF = 4;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic [1:0] hwy = 2'd0;
  logic [1:0] cntry = 2'd0;
  logic       ack = 1'b0;
  logic [2:0] hwy_lamp, cntry_lamp, fault_code;
  logic       fault;

  always #5 clk = ~clk;

  signal_conflict_monitor #(
    .MIN_YELLOW(MIN_YELLOW),
    .MIN_CLEAR (MIN_CLEAR),
    .FLASH_HALF(FLASH_HALF)
  ) dut (
    .clk       (clk),
    .clear     (clear),
    .hwy       (hwy),
    .cntry     (cntry),
    .ack       (ack),
    .hwy_lamp  (hwy_lamp),
    .cntry_lamp(cntry_lamp),
    .fault     (fault),
    .fault_code(fault_code)
  );

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  // Model state: mode 0=ARM 1=RUN 2=FAULT; run lengths are plain unsaturated counts.
  int         m_mode;
  int         m_prev[2];
  int         m_yrun[2];
  int         m_rrun;
  int         m_k;
  logic [2:0] m_hl, m_cl, m_code;
  logic       m_fault;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic logic [2:0] lamp_of(input int code);
    if (code == 1) return 3'b010;
    if (code == 2) return 3'b001;
    return 3'b100;
  endfunction

  // Legal progression on one approach is R->G->Y->R, or holding the same colour.
  function automatic int next_colour(input int code);
    if (code == 0) return 2;
    if (code == 2) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_rrun = 0; m_k = 0;
    for (int i = 0; i < 2; i++) begin
      m_prev[i] = 0;
      m_yrun[i] = 0;
    end
    m_hl = 3'b100; m_cl = 3'b100; m_fault = 1'b0; m_code = 3'd0;
  endtask

  task automatic model_step(input int h, input int c, input bit a);
    int cur[2];
    int code;
    bit seq_any, sy_any, sc_any;
    cur[0] = h; cur[1] = c;
    if (m_mode == 2) begin
      if (a && h == 0 && c == 0) begin
        m_mode = 0; m_fault = 1'b0; m_code = 3'd0;
        m_hl = 3'b100; m_cl = 3'b100;
      end else begin
        m_k++;
        m_hl = (((m_k / FLASH_HALF) % 2) == 0) ? 3'b100 : 3'b000;
        m_cl = m_hl;
      end
      return;
    end
    code = 0;
    seq_any = 1'b0; sy_any = 1'b0; sc_any = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (cur[i] != m_prev[i] && cur[i] != next_colour(m_prev[i])) seq_any = 1'b1;
      if (m_prev[i] == 1 && cur[i] == 0 && m_yrun[i] < MIN_YELLOW) sy_any = 1'b1;
      if (m_prev[i] == 0 && cur[i] == 2 && m_rrun < MIN_CLEAR) sc_any = 1'b1;
    end
    if (h == 3 || c == 3) code = 1;
    else if (h != 0 && c != 0) code = 2;
    else if (m_mode == 1 && seq_any) code = 3;
    else if (m_mode == 1 && sy_any) code = 4;
    else if (m_mode == 1 && sc_any) code = 5;
    if (code != 0) begin
      m_mode = 2; m_fault = 1'b1; m_code = code[2:0]; m_k = 0;
      m_hl = 3'b100; m_cl = 3'b100;
      m_yrun[0] = 0; m_yrun[1] = 0; m_rrun = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_yrun[i] = (cur[i] == 1) ? m_yrun[i] + 1 : 0;
        m_prev[i] = cur[i];
      end
      m_rrun = (h == 0 && c == 0) ? m_rrun + 1 : 0;
      m_mode = 1;
      m_hl = lamp_of(h); m_cl = lamp_of(c);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("hwy_lamp", hwy_lamp, m_hl);
      check("cntry_lamp", cntry_lamp, m_cl);
      check("fault", fault, m_fault);
      check("fault_code", fault_code, m_code);
    end
  end

  task automatic cycle(input int h, input int c, input bit a);
    hwy = h[1:0]; cntry = c[1:0]; ack = a;
    @(posedge clk);
    model_step(h, c, a);
    @(negedge clk);
  endtask

  task automatic async_clear();
    #1 clear = 1'b1;
    #1;
    check("clr_fault", fault, 0);
    check("clr_code", fault_code, 0);
    check("clr_hwy_lamp", hwy_lamp, 3'b100);
    check("clr_cntry_lamp", cntry_lamp, 3'b100);
    model_reset();
    #1 clear = 1'b0;
  endtask

  int seq_h[7] = '{2, 1, 0, 0, 0, 0, 2};
  int seq_c[7] = '{0, 0, 0, 2, 1, 0, 0};
  int seq_n[7] = '{5, 3, 2, 4, 3, 2, 1};
  int ph_h[6]  = '{2, 1, 0, 0, 0, 0};
  int ph_c[6]  = '{0, 0, 0, 2, 1, 0};

  initial begin
    int h, c;
    #1 clear = 1'b1;
    #1;
    check("rst_hwy_lamp", hwy_lamp, 3'b100);
    check("rst_cntry_lamp", cntry_lamp, 3'b100);
    check("rst_fault", fault, 0);
    check("rst_code", fault_code, 0);
    @(negedge clk);
    clear = 1'b0;
    model_reset();
    chk_en = 1'b1;

    // Legal full cycle
    for (int p = 0; p < 7; p++) begin
      for (int j = 0; j < seq_n[p]; j++) begin
        cycle(seq_h[p], seq_c[p], 1'b0);
        if (p == 0 && j == 4) check("legal_g_before_y", hwy_lamp, 3'b001);
        if (p == 1 && j == 0) check("legal_y_lag", hwy_lamp, 3'b010);
      end
    end
    check("legal_no_fault", fault, 0);

    // Short yellow, then flash cadence and acknowledge rules
    cycle(2, 0, 1'b0);
    cycle(1, 0, 1'b0);
    cycle(1, 0, 1'b0);
    cycle(0, 0, 1'b0);
    check("sy_fault", fault, 1);
    check("sy_code", fault_code, 4);
    check("sy_hwy_red", hwy_lamp, 3'b100);
    check("sy_cntry_red", cntry_lamp, 3'b100);
    for (int k = 1; k <= 8; k++) begin
      cycle(0, 2, 1'b0);
      if (k == 4) check("flash_off", hwy_lamp, 3'b000);
      if (k == 8) check("flash_on", cntry_lamp, 3'b100);
    end
    cycle(2, 0, 1'b1);
    check("ack_not_red", fault, 1);
    cycle(0, 0, 1'b1);
    check("ack_fault", fault, 0);
    check("ack_code", fault_code, 0);
    cycle(0, 0, 1'b0);
    check("arm_hwy", hwy_lamp, 3'b100);
    check("arm_cntry", cntry_lamp, 3'b100);

    // Invalid beats conflict, code sticks
    cycle(2, 3, 1'b0);
    check("invalid_code", fault_code, 1);
    cycle(2, 2, 1'b0);
    check("code_held", fault_code, 1);
    cycle(0, 0, 1'b1);

    // Sequence error, then short clear
    cycle(2, 0, 1'b0);
    cycle(2, 0, 1'b0);
    cycle(0, 0, 1'b0);
    check("seq_code", fault_code, 3);
    cycle(0, 0, 1'b1);
    cycle(2, 0, 1'b0);
    for (int j = 0; j < 3; j++) cycle(1, 0, 1'b0);
    cycle(0, 0, 1'b0);
    cycle(2, 0, 1'b0);
    check("short_clear_code", fault_code, 5);

    // Async clear while in FAULT
    async_clear();

    // Randomized traffic phases with random durations, glitches and acks
    for (int r = 0; r < 60; r++) begin
      for (int p = 0; p < 6; p++) begin
        int n;
        n = $urandom_range(1, 4);
        for (int j = 0; j < n; j++) begin
          h = ph_h[p]; c = ph_c[p];
          if ($urandom_range(0, 19) == 0) begin
            h = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
          end
          cycle(h, c, $urandom_range(0, 7) == 0);
          if (m_mode == 2) begin
            repeat ($urandom_range(0, 9))
              cycle($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3) == 0);
            cycle(0, 0, 1'b1);
          end
        end
      end
      if ($urandom_range(0, 29) == 0) async_clear();
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
